// File: rtl/coreaxitoahbl_cdc_handshake_tx_if.sv
// Source-side handshake bundle: local word hand-off plus toggle req/ack crossing
interface coreaxitoahbl_cdc_handshake_tx_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  srcValid;
  logic [DATA_WIDTH-1:0] srcData;
  logic                  srcReady;
  logic [DATA_WIDTH-1:0] xferData;
  logic                  xferReq;
  logic                  xferAck;
  logic                  xferDone;
  logic                  clrErr;
  logic                  timeoutErr;

  // Transmitter side
  modport slave (
    input  srcValid, srcData, xferAck, clrErr,
    output srcReady, xferData, xferReq, xferDone, timeoutErr
  );

  // Local producer / far-domain side
  modport master (
    output srcValid, srcData, xferAck, clrErr,
    input  srcReady, xferData, xferReq, xferDone, timeoutErr
  );
endinterface

// File: rtl/coreaxitoahbl_cdc_handshake_tx.sv
// Transmit end of a toggle req/ack clock-domain crossing: captures a word,
// holds it on xferData, toggles xferReq and waits for the synchronized ack.
module coreaxitoahbl_cdc_handshake_tx #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned NO_OF_REG_STAGES = 2,
  parameter int unsigned ACK_TIMEOUT      = 0
) (
  input logic                              CLK,
  input logic                              RESET,
  coreaxitoahbl_cdc_handshake_tx_if.slave  bus
);

  typedef enum logic [1:0] {FLUSH, IDLE, WAIT_ACK} state_e;

  localparam logic [15:0] FLUSH_LAST = 16'(NO_OF_REG_STAGES + 1);
  localparam logic [15:0] TIMEOUT    = 16'(ACK_TIMEOUT);

  state_e                      state_q, state_d;
  logic [NO_OF_REG_STAGES-1:0] sync_q;
  logic [15:0]                 cnt_q, cnt_d, cnt_inc;
  logic [DATA_WIDTH-1:0]       data_q, data_d;
  logic                        req_q, req_d;
  logic                        ready_q, ready_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        ack_sync;

  assign ack_sync = sync_q[NO_OF_REG_STAGES-1];
  assign cnt_inc  = cnt_q + 16'd1;

  // State, ack synchronizer and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= FLUSH;
      sync_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[NO_OF_REG_STAGES-2:0], bus.xferAck};
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      FLUSH:    if (cnt_q == FLUSH_LAST) state_d = IDLE;
      IDLE:     if (bus.srcValid) state_d = WAIT_ACK;
      WAIT_ACK: if (ack_sync == req_q) state_d = IDLE;
      default:  state_d = FLUSH;
    endcase
  end

  // Next values of the registered outputs and the shared flush/timeout counter
  always_comb begin
    cnt_d   = cnt_q;
    data_d  = data_q;
    req_d   = req_q;
    ready_d = 1'b0;
    done_d  = 1'b0;
    // clear first so a same-cycle timeout set below takes priority
    err_d   = bus.clrErr ? 1'b0 : err_q;
    case (state_q)
      FLUSH: begin
        if (cnt_q == FLUSH_LAST) ready_d = 1'b1;
        else                     cnt_d   = cnt_inc;
      end
      IDLE: begin
        if (bus.srcValid) begin
          data_d = bus.srcData;
          req_d  = ~req_q;
          cnt_d  = '0;
        end else begin
          ready_d = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (cnt_q != '1) cnt_d = cnt_inc;
        // fires only on the cycle the counter first reaches the limit
        if ((TIMEOUT != 16'd0) && (cnt_q != '1) && (cnt_inc == TIMEOUT)) err_d = 1'b1;
        if (ack_sync == req_q) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.srcReady   = ready_q;
  assign bus.xferData   = data_q;
  assign bus.xferReq    = req_q;
  assign bus.xferDone   = done_q;
  assign bus.timeoutErr = err_q;

endmodule

// File: tb/tb_coreaxitoahbl_cdc_handshake_tx.sv
// Scoreboard bench for the toggle handshake transmitter
module tb_coreaxitoahbl_cdc_handshake_tx;

  logic CLK = 1'b0;
  logic RESET;
  logic loop_en;
  logic ack_man;
  logic [2:0] ackpipe;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned done_cnt = 0;
  logic        exp_req  = 1'b0;
  logic [31:0] exp_q[$];

  coreaxitoahbl_cdc_handshake_tx_if #(.DATA_WIDTH(32)) bus ();

  coreaxitoahbl_cdc_handshake_tx #(
    .DATA_WIDTH(32), .NO_OF_REG_STAGES(2), .ACK_TIMEOUT(8)
  ) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Far-domain model: ack mirrors req three clocks later, or is held manually
  always @(posedge CLK) begin
    if (RESET) ackpipe <= '0;
    else       ackpipe <= {ackpipe[1:0], bus.xferReq};
  end
  assign bus.xferAck = loop_en ? ackpipe[2] : ack_man;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance one clock and score any completed transfer
  task automatic tick();
    @(posedge CLK);
    #1;
    if (bus.xferDone === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
      else                   check("sb_data", bus.xferData, exp_q.pop_front());
    end
  endtask

  // Offer a word (srcValid left high) and return one step after the accepting edge
  task automatic send_word(input logic [31:0] d);
    int unsigned n = 0;
    bus.srcData  = d;
    bus.srcValid = 1'b1;
    while (bus.srcReady !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    exp_q.push_back(d);
    tick();
    exp_req = ~exp_req;
    check("req_toggle", 32'(bus.xferReq), 32'(exp_req));
    check("ready_low", 32'(bus.srcReady), 32'd0);
    check("xdata_cap", bus.xferData, d);
  endtask

  task automatic wait_done(input int unsigned target);
    int unsigned n = 0;
    while (done_cnt < target && n < 40) begin
      tick();
      n++;
    end
    check("done_cnt", done_cnt, target);
  endtask

  task automatic do_reset_and_flush();
    int unsigned rise = 0;
    RESET = 1'b1;
    repeat (3) tick();
    check("rst_ready", 32'(bus.srcReady), 32'd0);
    check("rst_req", 32'(bus.xferReq), 32'd0);
    check("rst_data", bus.xferData, 32'd0);
    check("rst_done", 32'(bus.xferDone), 32'd0);
    check("rst_err", 32'(bus.timeoutErr), 32'd0);
    exp_req = 1'b0;
    exp_q.delete();
    RESET = 1'b0;
    for (int unsigned k = 1; k <= 10; k++) begin
      tick();
      if (bus.srcReady === 1'b1 && rise == 0) rise = k;
    end
    check("ready_rise", rise, 32'd4);
  endtask

  initial begin
    int unsigned dc;
    RESET = 1'b1; loop_en = 1'b1; ack_man = 1'b0;
    bus.srcValid = 1'b0; bus.srcData = '0; bus.clrErr = 1'b0;

    // Reset and flush timing
    do_reset_and_flush();

    // Single transfer with three-cycle loopback
    send_word(32'hA5A5_0001);
    bus.srcValid = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      check("t2_hold", bus.xferData, 32'hA5A5_0001);
      check("t2_nodone", 32'(bus.xferDone), 32'd0);
    end
    tick();
    check("t2_done", 32'(bus.xferDone), 32'd1);
    check("t2_ready", 32'(bus.srcReady), 32'd1);
    tick();
    check("t2_pulse", 32'(bus.xferDone), 32'd0);
    check("t2_cnt", done_cnt, 32'd1);
    check("t2_err", 32'(bus.timeoutErr), 32'd0);

    // Back-to-back with srcValid held
    for (int unsigned w = 1; w <= 4; w++) send_word(w);
    bus.srcValid = 1'b0;
    wait_done(5);
    check("t3_req", 32'(bus.xferReq), 32'(exp_req));
    check("t3_err", 32'(bus.timeoutErr), 32'd0);

    // Ack toggle while idle is ignored
    loop_en = 1'b0; ack_man = exp_req;
    tick();
    ack_man = ~exp_req;
    dc = done_cnt;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      check("idle_ready", 32'(bus.srcReady), 32'd1);
    end
    check("idle_nodone", done_cnt, dc);
    ack_man = exp_req;
    repeat (4) tick();

    // Timeout with ack withheld, late ack completes, clear
    send_word(32'h0000_BEEF);
    bus.srcValid = 1'b0;
    for (int unsigned i = 0; i < 7; i++) tick();
    check("t4_pre", 32'(bus.timeoutErr), 32'd0);
    tick();
    check("t4_set", 32'(bus.timeoutErr), 32'd1);
    repeat (4) tick();
    check("t4_wait", 32'(bus.xferReq), 32'(exp_req));
    check("t4_nodone", done_cnt, 32'd5);
    ack_man = exp_req;
    wait_done(6);
    check("t4_sticky", 32'(bus.timeoutErr), 32'd1);
    bus.clrErr = 1'b1;
    tick();
    bus.clrErr = 1'b0;
    check("t4_clr", 32'(bus.timeoutErr), 32'd0);

    // Clear coinciding with the timeout edge loses
    send_word(32'h0000_CAFE);
    bus.srcValid = 1'b0;
    for (int unsigned i = 0; i < 7; i++) tick();
    bus.clrErr = 1'b1;
    tick();
    check("t4_setwins", 32'(bus.timeoutErr), 32'd1);
    tick();
    bus.clrErr = 1'b0;
    check("t4_clr2", 32'(bus.timeoutErr), 32'd0);
    ack_man = exp_req;
    wait_done(7);
    loop_en = 1'b1;
    repeat (4) tick();

    // Reset while waiting for ack
    do_reset_and_flush();
    loop_en = 1'b0; ack_man = 1'b0;
    send_word(32'h1234_5678);
    bus.srcValid = 1'b0;
    repeat (2) tick();
    dc = done_cnt;
    do_reset_and_flush();
    check("t5_req", 32'(bus.xferReq), 32'd0);
    check("t5_nodone", done_cnt, dc);
    loop_en = 1'b1;
    repeat (4) tick();

    // New data ignored while busy
    send_word(32'h0000_00AA);
    bus.srcData = 32'h0000_00BB;
    dc = done_cnt;
    for (int unsigned i = 0; i < 20 && done_cnt == dc; i++) begin
      check("t6_hold", bus.xferData, 32'h0000_00AA);
      tick();
    end
    bus.srcValid = 1'b0;
    check("t6_done", done_cnt, dc + 1);
    send_word(32'h0000_00BB);
    bus.srcValid = 1'b0;
    wait_done(dc + 2);
    check("t6_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
